// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: device frame formats, rejection causes and FSM encoding for the DAC SPI monitor
package dac_spi_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK, S_WAIT_HIGH} state_t;
  typedef enum logic [1:0] {DEV_AD5660, DEV_AD5640, DEV_LTC2630} dev_t;
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_SHORT   = 2'd1;
  localparam logic [1:0] ERR_LONG    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
  localparam logic [4:0] BITS_AD5660  = 5'd24;
  localparam logic [4:0] BITS_AD5640  = 5'd16;
  localparam logic [4:0] BITS_LTC2630 = 5'd24;
  localparam int AD5660_PD_LSB = 16;
  localparam int AD5640_PD_LSB = 14;
  localparam int LTC_CMD_LSB   = 20;
  function automatic logic [4:0] frame_bits(input dev_t d);
    return d == DEV_AD5640 ? BITS_AD5640 : d == DEV_AD5660 ? BITS_AD5660 : BITS_LTC2630;
  endfunction
endpackage

// File: rtl/dac_spi_sync.sv
// dac_spi_sync: 2-flop synchronizer plus delay stage for the three SPI lines, with registered edge strobes
module dac_spi_sync (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] din,
  output logic [2:0] level,
  output logic [2:0] rise,
  output logic [2:0] fall
);
  logic [2:0] s1, s2;
  // strobes are computed against the delay stage so they line up with level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= '0;
      s2    <= '0;
      level <= '0;
      rise  <= '0;
      fall  <= '0;
    end else begin
      s1    <= din;
      s2    <= s1;
      level <= s2;
      rise  <= s2 & ~level;
      fall  <= ~s2 & level;
    end
  end
endmodule

// File: rtl/dac_spi_monitor.sv
// dac_spi_monitor: oversampling SPI frame decoder and length checker for the trim-DAC link
module dac_spi_monitor
  import dac_spi_pkg::*;
#(
  parameter string DEVICE         = "AD5640",
  parameter int    TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        sync_n,
  input  logic        clr_counts,
  output logic [15:0] code,
  output logic [3:0]  ctrl,
  output logic        code_valid,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count
);
  localparam dev_t DEV = DEVICE == "AD5660" ? DEV_AD5660 : DEVICE == "AD5640" ? DEV_AD5640 : DEV_LTC2630;
  localparam logic [4:0] FB = frame_bits(DEV);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [2:0] level, rise, fall;
  logic sample, good, bad, unused;
  logic [1:0] cause;
  logic [23:0] sr;
  logic [4:0] bitcnt;
  logic [TW-1:0] tcnt;
  logic [15:0] code_nx;
  logic [3:0] ctrl_nx;
  state_t state, state_nx;

  dac_spi_sync u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .din    ({sync_n, mosi, sclk}),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  assign unused = ^{rise[1], fall[1], level[0]};
  assign sample = DEV == DEV_LTC2630 ? rise[0] : fall[0];
  assign code_nx = DEV == DEV_AD5640 ? {sr[13:0], 2'b00} : sr[15:0];
  assign ctrl_nx = DEV == DEV_LTC2630 ? sr[LTC_CMD_LSB +: 4]
                 : DEV == DEV_AD5640 ? {2'b00, sr[AD5640_PD_LSB +: 2]} : {2'b00, sr[AD5660_PD_LSB +: 2]};

  // next state and the one-cycle accept/reject decision
  always_comb begin
    state_nx = state;
    good     = 1'b0;
    bad      = 1'b0;
    cause    = ERR_NONE;
    case (state)
      S_IDLE:      state_nx = fall[2] ? S_SHIFT : S_IDLE;
      S_SHIFT: begin
        if (rise[2]) state_nx = S_CHECK;
        else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_nx = S_WAIT_HIGH;
          bad      = 1'b1;
          cause    = ERR_TIMEOUT;
        end
      end
      S_CHECK: begin
        state_nx = S_IDLE;
        good     = bitcnt == FB;
        bad      = bitcnt != FB;
        cause    = bitcnt < FB ? ERR_SHORT : ERR_LONG;
      end
      default:     state_nx = level[2] ? S_IDLE : S_WAIT_HIGH;
    endcase
  end

  // state, deserializer, timeout counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      sr          <= '0;
      bitcnt      <= '0;
      tcnt        <= '0;
      code        <= '0;
      ctrl        <= '0;
      code_valid  <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= ERR_NONE;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && fall[2]) begin
        bitcnt <= '0;
        tcnt   <= '0;
      end else if (state == S_SHIFT) begin
        tcnt <= tcnt + 1'b1;
        if (sample) begin
          sr     <= {sr[22:0], level[1]};
          bitcnt <= bitcnt + (bitcnt != 5'd31 ? 5'd1 : 5'd0);
        end
      end
      code_valid <= good;
      frame_err  <= bad;
      if (good) begin
        code <= code_nx;
        ctrl <= ctrl_nx;
      end
      if (bad) err_code <= cause;
      frame_count <= clr_counts ? '0 : good ? frame_count + 16'd1 : frame_count;
      err_count   <= clr_counts ? '0 : (bad && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
    end
  end
endmodule

// File: tb/tb_dac_spi_monitor.sv
// tb_dac_spi_monitor: directed checks of the three device variants of dac_spi_monitor
module tb_dac_spi_monitor;
  logic clk = 0, reset_n = 0, sclk = 0, mosi = 0, clr_counts = 0;
  logic [2:0] sn = 3'b111;
  logic [15:0] code [3];
  logic [3:0] ctrl [3];
  logic [2:0] cvld, ferr;
  logic [1:0] ecode [3];
  logic [15:0] fcnt [3];
  logic [7:0] ecnt [3];
  int cv [3] = '{0, 0, 0};
  int fe [3] = '{0, 0, 0};
  int compared = 0, mismatched = 0;
  int c0, f0;

  always #5 clk = ~clk;

  dac_spi_monitor #(.DEVICE("AD5660"), .TIMEOUT_CYCLES(4096)) u_ad5660 (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .mosi(mosi), .sync_n(sn[0]), .clr_counts(clr_counts),
    .code(code[0]), .ctrl(ctrl[0]), .code_valid(cvld[0]), .frame_err(ferr[0]), .err_code(ecode[0]),
    .frame_count(fcnt[0]), .err_count(ecnt[0]));
  dac_spi_monitor #(.DEVICE("AD5640"), .TIMEOUT_CYCLES(4096)) u_ad5640 (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .mosi(mosi), .sync_n(sn[1]), .clr_counts(clr_counts),
    .code(code[1]), .ctrl(ctrl[1]), .code_valid(cvld[1]), .frame_err(ferr[1]), .err_code(ecode[1]),
    .frame_count(fcnt[1]), .err_count(ecnt[1]));
  dac_spi_monitor #(.DEVICE("LTC2630"), .TIMEOUT_CYCLES(4096)) u_ltc2630 (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .mosi(mosi), .sync_n(sn[2]), .clr_counts(clr_counts),
    .code(code[2]), .ctrl(ctrl[2]), .code_valid(cvld[2]), .frame_err(ferr[2]), .err_code(ecode[2]),
    .frame_count(fcnt[2]), .err_count(ecnt[2]));

  // count output pulses so each test can check how many it produced
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      cv[i] <= cv[i] + (cvld[i] ? 1 : 0);
      fe[i] <= fe[i] + (ferr[i] ? 1 : 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // skew flips mosi while sclk is high, so only a rising-edge sampler sees the true bit
  task automatic put_bit(input logic b, input logic skew);
    mosi = b;
    cyc(4);
    sclk = 1;
    cyc(4);
    if (skew) begin
      mosi = ~b;
      cyc(4);
    end
    sclk = 0;
    cyc(4);
  endtask

  task automatic send(input int d, input logic [31:0] data, input int n, input logic skew);
    sn[d] = 0;
    cyc(4);
    for (int i = n - 1; i >= 0; i--) put_bit(data[i], skew);
    sn[d] = 1;
    cyc(12);
  endtask

  task automatic test_reset;
    reset_n = 0;
    cyc(3);
    reset_n = 1;
    cyc(2);
    compared++; if (code[0] !== 16'h0) begin mismatched++; $display("FAIL reset_code got %h want 0000", code[0]); end
    compared++; if (ctrl[0] !== 4'h0) begin mismatched++; $display("FAIL reset_ctrl got %h want 0", ctrl[0]); end
    compared++; if (cvld !== 3'b000 || ferr !== 3'b000) begin mismatched++; $display("FAIL reset_pulses got %b/%b want 000/000", cvld, ferr); end
    compared++; if (ecode[0] !== 2'd0) begin mismatched++; $display("FAIL reset_err_code got %0d want 0", ecode[0]); end
    compared++; if (fcnt[0] !== 16'd0 || ecnt[0] !== 8'd0) begin mismatched++; $display("FAIL reset_counts got %0d/%0d want 0/0", fcnt[0], ecnt[0]); end
  endtask

  task automatic test_ad5660;
    c0 = cv[0]; f0 = fe[0];
    send(0, 32'h008A3C, 24, 0);
    compared++; if (code[0] !== 16'h8A3C) begin mismatched++; $display("FAIL ad5660_code got %h want 8a3c", code[0]); end
    compared++; if (ctrl[0] !== 4'h0) begin mismatched++; $display("FAIL ad5660_ctrl got %h want 0", ctrl[0]); end
    compared++; if (cv[0] - c0 !== 1 || fe[0] - f0 !== 0) begin mismatched++; $display("FAIL ad5660_pulses got %0d/%0d want 1/0", cv[0] - c0, fe[0] - f0); end
    compared++; if (fcnt[0] !== 16'd1) begin mismatched++; $display("FAIL ad5660_count got %0d want 1", fcnt[0]); end
  endtask

  task automatic test_ad5640;
    send(1, 32'h3FFF, 16, 0);
    compared++; if (code[1] !== 16'hFFFC || ctrl[1] !== 4'h0) begin mismatched++; $display("FAIL ad5640_full got %h/%h want fffc/0", code[1], ctrl[1]); end
    c0 = cv[1];
    send(1, 32'h4001, 16, 0);
    compared++; if (code[1] !== 16'h0004 || ctrl[1] !== 4'h1) begin mismatched++; $display("FAIL ad5640_pd got %h/%h want 0004/1", code[1], ctrl[1]); end
    compared++; if (fcnt[1] !== 16'd2 || cv[1] - c0 !== 1) begin mismatched++; $display("FAIL ad5640_count got %0d/%0d want 2/1", fcnt[1], cv[1] - c0); end
  endtask

  task automatic test_edge_select;
    send(2, 32'h307FFF, 24, 1);
    compared++; if (code[2] !== 16'h7FFF || ctrl[2] !== 4'h3) begin mismatched++; $display("FAIL ltc_rise got %h/%h want 7fff/3", code[2], ctrl[2]); end
    compared++; if (fcnt[2] !== 16'd1) begin mismatched++; $display("FAIL ltc_count got %0d want 1", fcnt[2]); end
    send(0, 32'h001234, 24, 1);
    compared++; if (code[0] !== 16'hEDCB || ctrl[0] !== 4'h3) begin mismatched++; $display("FAIL ad5660_fall got %h/%h want edcb/3", code[0], ctrl[0]); end
  endtask

  task automatic test_length_errors;
    f0 = fe[0]; c0 = cv[0];
    send(0, 32'h0055AA, 23, 0);
    compared++; if (ecode[0] !== 2'd1 || ecnt[0] !== 8'd1) begin mismatched++; $display("FAIL short_err got %0d/%0d want 1/1", ecode[0], ecnt[0]); end
    compared++; if (fe[0] - f0 !== 1) begin mismatched++; $display("FAIL short_pulse got %0d want 1", fe[0] - f0); end
    send(0, 32'h1AA55A, 25, 0);
    compared++; if (ecode[0] !== 2'd2 || ecnt[0] !== 8'd2) begin mismatched++; $display("FAIL long_err got %0d/%0d want 2/2", ecode[0], ecnt[0]); end
    compared++; if (code[0] !== 16'hEDCB || fcnt[0] !== 16'd2 || cv[0] - c0 !== 0) begin mismatched++; $display("FAIL err_keep_code got %h/%0d/%0d want edcb/2/0", code[0], fcnt[0], cv[0] - c0); end
  endtask

  task automatic test_timeout;
    f0 = fe[0]; c0 = cv[0];
    sn[0] = 0;
    cyc(4000);
    compared++; if (ecode[0] !== 2'd2 || fe[0] - f0 !== 0) begin mismatched++; $display("FAIL timeout_early got %0d/%0d want 2/0", ecode[0], fe[0] - f0); end
    cyc(1000);
    compared++; if (ecode[0] !== 2'd3 || ecnt[0] !== 8'd3 || fe[0] - f0 !== 1) begin mismatched++; $display("FAIL timeout_err got %0d/%0d/%0d want 3/3/1", ecode[0], ecnt[0], fe[0] - f0); end
    sn[0] = 1;
    cyc(12);
    compared++; if (cv[0] - c0 !== 0 || fcnt[0] !== 16'd2) begin mismatched++; $display("FAIL timeout_late_rise got %0d/%0d want 0/2", cv[0] - c0, fcnt[0]); end
    send(0, 32'h015555, 24, 0);
    compared++; if (code[0] !== 16'h5555 || ctrl[0] !== 4'h1 || fcnt[0] !== 16'd3) begin mismatched++; $display("FAIL timeout_recover got %h/%h/%0d want 5555/1/3", code[0], ctrl[0], fcnt[0]); end
  endtask

  task automatic test_reset_mid_frame;
    sn[0] = 0;
    cyc(4);
    for (int i = 0; i < 10; i++) put_bit(i[0], 0);
    reset_n = 0;
    cyc(3);
    compared++; if (code[0] !== 16'h0 || ctrl[0] !== 4'h0 || ecode[0] !== 2'd0) begin mismatched++; $display("FAIL midreset_out got %h/%h/%0d want 0000/0/0", code[0], ctrl[0], ecode[0]); end
    compared++; if (fcnt[0] !== 16'd0 || ecnt[0] !== 8'd0) begin mismatched++; $display("FAIL midreset_counts got %0d/%0d want 0/0", fcnt[0], ecnt[0]); end
    reset_n = 1;
    cyc(4);
    c0 = cv[0]; f0 = fe[0];
    sn[0] = 1;
    cyc(12);
    compared++; if (cv[0] - c0 !== 0 || fe[0] - f0 !== 0) begin mismatched++; $display("FAIL midreset_stale got %0d/%0d want 0/0", cv[0] - c0, fe[0] - f0); end
    send(0, 32'h00ABCD, 24, 0);
    compared++; if (code[0] !== 16'hABCD || fcnt[0] !== 16'd1) begin mismatched++; $display("FAIL midreset_next got %h/%0d want abcd/1", code[0], fcnt[0]); end
  endtask

  task automatic test_clear;
    c0 = cv[0];
    sn[0] = 0;
    cyc(4);
    for (int i = 23; i >= 0; i--) begin
      logic [23:0] w;
      w = 24'h021111;
      put_bit(w[i], 0);
    end
    clr_counts = 1;
    sn[0] = 1;
    cyc(12);
    clr_counts = 0;
    compared++; if (code[0] !== 16'h1111 || ctrl[0] !== 4'h2 || cv[0] - c0 !== 1) begin mismatched++; $display("FAIL clear_decode got %h/%h/%0d want 1111/2/1", code[0], ctrl[0], cv[0] - c0); end
    compared++; if (fcnt[0] !== 16'd0) begin mismatched++; $display("FAIL clear_wins got %0d want 0", fcnt[0]); end
    send(0, 32'h002222, 24, 0);
    compared++; if (fcnt[0] !== 16'd1 || code[0] !== 16'h2222) begin mismatched++; $display("FAIL clear_after got %0d/%h want 1/2222", fcnt[0], code[0]); end
  endtask

  initial begin
    test_reset;
    test_ad5660;
    test_ad5640;
    test_edge_select;
    test_length_errors;
    test_timeout;
    test_reset_mid_frame;
    test_clear;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
